// File: rtl/exc_if.sv
// Writeback/CP0/fetch-side signal bundle of the exception sequencer.
// Latency: none (wires only).
// Backpressure: redirect_valid/redirect_ready handshake toward fetch.
interface exc_if;
    // writeback stage
    logic        wb_valid;
    logic        wb_ex_req;
    logic [4:0]  wb_excode;
    logic        wb_eret;
    logic [31:0] wb_pc;
    logic        wb_bd;
    // CP0 state
    logic        cp0_status_ie;
    logic        cp0_status_exl;
    logic [7:0]  cp0_status_im;
    logic [7:0]  cp0_cause_ip;
    logic [31:0] cp0_epc;
    // fetch
    logic        redirect_ready;
    // sequencer outputs
    logic        wb_ex;
    logic        eret_flush;
    logic [4:0]  ex_excode;
    logic [31:0] ex_epc;
    logic        ex_bd;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    // Pipeline / CP0 / fetch side.
    modport master (
        output wb_valid, wb_ex_req, wb_excode, wb_eret, wb_pc, wb_bd,
               cp0_status_ie, cp0_status_exl, cp0_status_im, cp0_cause_ip,
               cp0_epc, redirect_ready,
        input  wb_ex, eret_flush, ex_excode, ex_epc, ex_bd, flush,
               redirect_valid, redirect_pc, busy
    );

    // Sequencer side.
    modport slave (
        input  wb_valid, wb_ex_req, wb_excode, wb_eret, wb_pc, wb_bd,
               cp0_status_ie, cp0_status_exl, cp0_status_im, cp0_cause_ip,
               cp0_epc, redirect_ready,
        output wb_ex, eret_flush, ex_excode, ex_epc, ex_bd, flush,
               redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt/ERET sequencer: CP0 strobe, pipeline flush, fetch redirect.
// Latency: strobe+flush in accept cycle, redirect offered FLUSH_CYCLES+1 cycles later.
// Backpressure: holds redirect until redirect_ready; inputs ignored while busy.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    exc_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        target_q, target_d;

    logic int_pending;
    logic accept;
    logic take_int;
    logic take_exc;
    logic take_eret;

    // Interrupts are masked while EXL is set, so a prior event masks them.
    assign int_pending = bus.cp0_status_ie & ~bus.cp0_status_exl &
                         (|(bus.cp0_status_im & bus.cp0_cause_ip));

    // Accept only from IDLE; no strobe may leak out while reset is held.
    assign accept    = (state_q == ST_IDLE) & ~reset & bus.wb_valid &
                       (int_pending | bus.wb_ex_req | bus.wb_eret);
    assign take_int  = accept & int_pending;
    assign take_exc  = accept & (int_pending | bus.wb_ex_req);
    assign take_eret = accept & ~take_exc;

    // State, drain counter and redirect target registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // Next state: accept -> drain FLUSH_CYCLES cycles -> offer redirect until taken.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                    target_d = take_exc ? EXC_VECTOR : bus.cp0_epc;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: CP0 fields only in the accept cycle, zero otherwise.
    always_comb begin
        bus.wb_ex          = take_exc;
        bus.eret_flush     = take_eret;
        bus.ex_excode      = '0;
        bus.ex_epc         = '0;
        bus.ex_bd          = 1'b0;
        if (take_exc) begin
            bus.ex_excode = take_int ? 5'h00 : bus.wb_excode;
            bus.ex_epc    = bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
            bus.ex_bd     = bus.wb_bd;
        end
        bus.flush          = accept | (state_q == ST_FLUSH);
        bus.redirect_valid = (state_q == ST_REDIRECT);
        bus.redirect_pc    = (state_q == ST_REDIRECT) ? target_q : 32'd0;
        bus.busy           = (state_q != ST_IDLE);
    end
endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_if bus ();

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: timeline since the accepted event
    bit          m_act = 1'b0;
    int          m_k   = 0;
    logic [31:0] m_tgt = 32'd0;
    bit          m_acc;
    bit          m_isx;

    // observed counters for directed scenarios
    int          n_wbex, n_flush, n_rv;
    logic [31:0] last_rpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.wb_valid       = 1'b0;
        bus.wb_ex_req      = 1'b0;
        bus.wb_excode      = 5'd0;
        bus.wb_eret        = 1'b0;
        bus.wb_pc          = 32'd0;
        bus.wb_bd          = 1'b0;
        bus.cp0_status_ie  = 1'b0;
        bus.cp0_status_exl = 1'b0;
        bus.cp0_status_im  = 8'd0;
        bus.cp0_cause_ip   = 8'd0;
        bus.cp0_epc        = 32'd0;
        bus.redirect_ready = 1'b0;
    endtask

    // Mid-cycle: compare every output against the model.
    task automatic observe();
        bit          ip_now;
        bit          e_flush, e_rv, e_busy;
        logic [31:0] e_epc;
        @(negedge clk);
        #1;
        ip_now = bus.cp0_status_ie && !bus.cp0_status_exl &&
                 ((bus.cp0_status_im & bus.cp0_cause_ip) != 8'd0);
        if (!m_act) begin
            m_acc   = !reset && bus.wb_valid && (ip_now || bus.wb_ex_req || bus.wb_eret);
            m_isx   = m_acc && (ip_now || bus.wb_ex_req);
            e_flush = m_acc;
            e_rv    = 1'b0;
            e_busy  = 1'b0;
        end else begin
            m_acc   = 1'b0;
            m_isx   = 1'b0;
            e_flush = (m_k <= F);
            e_rv    = (m_k > F);
            e_busy  = 1'b1;
        end
        chk("wb_ex",          32'(bus.wb_ex),          32'(m_isx));
        chk("eret_flush",     32'(bus.eret_flush),     32'(m_acc && !m_isx));
        chk("flush",          32'(bus.flush),          32'(e_flush));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
        chk("busy",           32'(bus.busy),           32'(e_busy));
        if (m_isx) begin
            e_epc = bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
            chk("ex_excode", 32'(bus.ex_excode), ip_now ? 32'd0 : 32'(bus.wb_excode));
            chk("ex_epc",    bus.ex_epc,         e_epc);
            chk("ex_bd",     32'(bus.ex_bd),     32'(bus.wb_bd));
        end
        if (e_rv) chk("redirect_pc", bus.redirect_pc, m_tgt);
        if (bus.wb_ex) n_wbex++;
        if (bus.flush) n_flush++;
        if (bus.redirect_valid) begin
            n_rv++;
            last_rpc = bus.redirect_pc;
        end
    endtask

    // Clock edge: advance the model with the inputs seen this cycle.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_act = 1'b0;
            m_tgt = 32'd0;
        end else if (!m_act) begin
            if (m_acc) begin
                m_act = 1'b1;
                m_k   = 1;
                m_tgt = m_isx ? VEC : bus.cp0_epc;
            end
        end else if (m_k > F) begin
            if (bus.redirect_ready) m_act = 1'b0;
        end else begin
            m_k++;
        end
        #1;
    endtask

    task automatic cycle();
        observe();
        advance();
    endtask

    task automatic zero_cnt();
        n_wbex   = 0;
        n_flush  = 0;
        n_rv     = 0;
        last_rpc = 32'd0;
    endtask

    task automatic exc_setup(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        clear_in();
        bus.wb_valid       = 1'b1;
        bus.wb_ex_req      = 1'b1;
        bus.wb_excode      = code;
        bus.wb_pc          = pc;
        bus.wb_bd          = bd;
        bus.redirect_ready = 1'b1;
    endtask

    // Drop WB inputs after the accept cycle and let the event drain.
    task automatic drain();
        bus.wb_valid  = 1'b0;
        bus.wb_ex_req = 1'b0;
        bus.wb_eret   = 1'b0;
        bus.cp0_epc   = 32'd0;
        bus.redirect_ready = 1'b1;
        repeat (6) cycle();
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        advance();
        advance();
        // reset state, with a request present to prove it is blocked
        bus.wb_valid  = 1'b1;
        bus.wb_ex_req = 1'b1;
        observe();
        chk("rst_wb_ex", 32'(bus.wb_ex), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_rpc",   bus.redirect_pc, 32'd0);
        advance();
        clear_in();
        reset = 1'b0;
        cycle();

        // exception
        zero_cnt();
        exc_setup(5'h0C, 32'hBFC00100, 1'b0);
        observe();
        chk("exc_strobe", 32'(bus.wb_ex),     32'd1);
        chk("exc_code",   32'(bus.ex_excode), 32'h0C);
        chk("exc_epc",    bus.ex_epc,         32'hBFC00100);
        chk("exc_bd",     32'(bus.ex_bd),     32'd0);
        advance();
        drain();
        chk("exc_flush_len", 32'(n_flush), 32'd3);
        chk("exc_rv_len",    32'(n_rv),    32'd1);
        chk("exc_strobes",   32'(n_wbex),  32'd1);
        chk("exc_redir_pc",  last_rpc,     VEC);

        // delay slot with PC wrap
        exc_setup(5'h0C, 32'h00000000, 1'b1);
        observe();
        chk("ds_epc", bus.ex_epc,     32'hFFFFFFFC);
        chk("ds_bd",  32'(bus.ex_bd), 32'd1);
        advance();
        drain();

        // priority: interrupt beats exception, masked by EXL
        for (int e = 0; e < 2; e++) begin
            exc_setup(5'h04, 32'h80000040, 1'b0);
            bus.cp0_status_ie  = 1'b1;
            bus.cp0_status_exl = e[0];
            bus.cp0_status_im  = 8'h80;
            bus.cp0_cause_ip   = 8'h80;
            observe();
            chk(e == 0 ? "prio_int" : "prio_exl", 32'(bus.ex_excode), e == 0 ? 32'h00 : 32'h04);
            advance();
            drain();
        end

        // ERET
        zero_cnt();
        clear_in();
        bus.wb_valid = 1'b1;
        bus.wb_eret  = 1'b1;
        bus.cp0_epc  = 32'h80001234;
        observe();
        chk("eret_pulse", 32'(bus.eret_flush), 32'd1);
        chk("eret_no_ex", 32'(bus.wb_ex),      32'd0);
        advance();
        drain();
        chk("eret_target", last_rpc, 32'h80001234);

        // handshake stall with ignored requests while busy
        zero_cnt();
        exc_setup(5'h08, 32'h00400000, 1'b0);
        bus.redirect_ready = 1'b0;
        cycle();
        repeat (F) cycle();
        for (int i = 0; i < 5; i++) begin
            observe();
            chk("hs_rv", 32'(bus.redirect_valid), 32'd1);
            chk("hs_pc", bus.redirect_pc,         VEC);
            advance();
        end
        bus.wb_valid       = 1'b0;
        bus.redirect_ready = 1'b1;
        cycle();
        observe();
        chk("hs_idle",    32'(bus.busy), 32'd0);
        chk("hs_strobes", 32'(n_wbex),   32'd1);
        advance();

        // reset in FLUSH, then in REDIRECT
        for (int r = 0; r < 2; r++) begin
            exc_setup(5'h0C, 32'h00001000, 1'b0);
            bus.redirect_ready = 1'b0;
            cycle();
            bus.wb_valid = 1'b0;
            if (r == 1) repeat (F) cycle();
            reset = 1'b1;
            cycle();
            reset = 1'b0;
            observe();
            chk("mid_rst_busy",  32'(bus.busy),           32'd0);
            chk("mid_rst_flush", 32'(bus.flush),          32'd0);
            chk("mid_rst_rv",    32'(bus.redirect_valid), 32'd0);
            advance();
        end
        exc_setup(5'h0D, 32'h00002000, 1'b0);
        observe();
        chk("post_rst_accept", 32'(bus.wb_ex), 32'd1);
        advance();
        drain();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            bus.wb_valid       = ($urandom_range(0, 1) == 1);
            bus.wb_ex_req      = ($urandom_range(0, 3) == 0);
            bus.wb_excode      = 5'($urandom);
            bus.wb_eret        = ($urandom_range(0, 3) == 0);
            bus.wb_pc          = {$urandom} & 32'hFFFFFFFC;
            bus.wb_bd          = ($urandom_range(0, 1) == 1);
            bus.cp0_status_ie  = ($urandom_range(0, 1) == 1);
            bus.cp0_status_exl = ($urandom_range(0, 2) == 0);
            bus.cp0_status_im  = 8'($urandom);
            bus.cp0_cause_ip   = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
            bus.cp0_epc        = $urandom;
            bus.redirect_ready = ($urandom_range(0, 1) == 1);
            reset              = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer between the writeback stage and CP0. It arbitrates pending interrupts, WB-stage exceptions and ERET, and emits the one-cycle `wb_ex` / `eret_flush` strobes with excode, EPC and BD to CP0. It then holds a pipeline-wide flush for a fixed drain period and hands a redirect PC to fetch through a valid/ready handshake. At most one event is in flight at a time.

## Interface
- `EXC_VECTOR`, default `32'hBFC00380`: redirect target for interrupts and exceptions (BEV=1).
- `FLUSH_CYCLES`, default `2`: cycles spent in FLUSH after the accept cycle. Must be ≥1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wb_valid` in 1: a valid instruction occupies WB this cycle.
- `wb_ex_req` in 1: the WB instruction carries an exception.
- `wb_excode` in 5: excode of that exception.
- `wb_eret` in 1: the WB instruction is ERET.
- `wb_pc` in 32: PC of the WB instruction.
- `wb_bd` in 1: the WB instruction is in a branch delay slot.
- `cp0_status_ie` in 1: Status.IE.
- `cp0_status_exl` in 1: Status.EXL.
- `cp0_status_im` in 8: Status.IM.
- `cp0_cause_ip` in 8: Cause.IP.
- `cp0_epc` in 32: current EPC, used as the ERET target.
- `redirect_ready` in 1: fetch accepts the redirect.
- `wb_ex` out 1: exception strobe to CP0.
- `eret_flush` out 1: ERET strobe to CP0.
- `ex_excode` out 5: excode written to Cause; valid while `wb_ex`=1.
- `ex_epc` out 32: value written to EPC; valid while `wb_ex`=1.
- `ex_bd` out 1: value written to Cause.BD; valid while `wb_ex`=1.
- `flush` out 1: squash all pipeline stages.
- `redirect_valid` out 1: redirect PC offered to fetch.
- `redirect_pc` out 32: new fetch PC.
- `busy` out 1: state ≠ IDLE.

## Operation
- `int_pending` = `cp0_status_ie` & ~`cp0_status_exl` & |(`cp0_status_im` & `cp0_cause_ip`).
- States are IDLE, FLUSH and REDIRECT. All outputs are 0 in reset and in IDLE with no event.
- An event is accepted only in IDLE with `wb_valid`=1 and at least one of `int_pending`, `wb_ex_req`, `wb_eret` set.
- Priority is interrupt > `wb_ex_req` > `wb_eret`.
- Interrupt event: `wb_ex`=1 and `ex_excode`=5'h00.
- Exception event: `wb_ex`=1 and `ex_excode`=`wb_excode`.
- ERET event: `eret_flush`=1 and `wb_ex`=0.
- For interrupt and exception events, `ex_epc` = `wb_bd` ? `wb_pc`−4 : `wb_pc` (32-bit wrap), and `ex_bd`=`wb_bd`.
- `ex_*`, `wb_ex` and `eret_flush` are combinational in the accept cycle only. They are never asserted outside IDLE.
- On accept:
  - Register the target: `cp0_epc` for ERET, `EXC_VECTOR` otherwise.
  - Assert `flush` combinationally.
  - Load the counter with `FLUSH_CYCLES`−1.
  - Go to FLUSH.
- FLUSH: `flush`=1. Decrement the counter each cycle; at 0, go to REDIRECT.
- REDIRECT: `flush`=0, `redirect_valid`=1, and `redirect_pc` holds the registered target. Exit to IDLE in the cycle where `redirect_ready`=1.
- Inputs are ignored outside IDLE. Requests arriving then are lost by design, because the flush squashes them.
- `redirect_pc` is stable while `redirect_valid`=1 and is not updated until the next accept.
- Reset in any state forces IDLE on the next edge. Counter and target return to 0, and all outputs are 0 from that edge.

## Timing
- Accept at cycle T:
  - CP0 strobe and `flush` are high in T.
  - `flush` is high through T+`FLUSH_CYCLES`.
  - `redirect_valid` is first high at T+`FLUSH_CYCLES`+1.
- Minimum event-to-IDLE time is `FLUSH_CYCLES`+2 cycles, reached when `redirect_ready` is high on the first offer cycle.
- A new accept is possible in the cycle after the `redirect_ready` handshake.
- Back-to-back events therefore have a minimum spacing of `FLUSH_CYCLES`+2 cycles.
- CP0 samples `wb_ex` and `eret_flush` at the T edge.
- `int_pending` is evaluated on the T-cycle CP0 values. An EXL set by a prior event therefore masks interrupts.

## Test plan
- **Exception:** `wb_valid`=1, `wb_ex_req`=1, `wb_excode`=5'h0C, `wb_pc`=0xBFC00100, `wb_bd`=0, `redirect_ready`=1.
  - Expect `wb_ex`=1 for one cycle with excode 0x0C, EPC 0xBFC00100, BD=0.
  - Expect `flush` high for 3 cycles, then `redirect_pc`=0xBFC00380 for 1 cycle, then IDLE.
- **Delay slot:** same as above with `wb_bd`=1 and `wb_pc`=0x00000000.
  - Expect `ex_epc`=0xFFFFFFFC (wrap) and `ex_bd`=1.
- **Priority:** IE=1, EXL=0, IM=0x80, IP=0x80, `wb_ex_req`=1 with excode 0x04.
  - Expect `ex_excode`=0x00.
  - Repeat with EXL=1: expect excode 0x04.
- **ERET:** `wb_eret`=1, `cp0_epc`=0x80001234.
  - Expect `eret_flush` pulse, `wb_ex`=0, `redirect_pc`=0x80001234.
- **Handshake and busy:**
  - Hold `redirect_ready`=0 for 5 cycles: `redirect_valid` and `redirect_pc` stay stable.
  - Drive `wb_ex_req`=1 during FLUSH/REDIRECT: no second strobe.
  - Raise `redirect_ready`: IDLE next cycle.
- **Reset mid-operation:** assert `reset` in FLUSH and again in REDIRECT.
  - Expect all outputs 0 on the next edge and `busy`=0.
  - A new exception is accepted normally afterwards.
